// File: rtl/sram_controller_if.sv
// MEM-stage side of the SRAM controller: LD/ST strobes, address, store data and stall handshake.
interface sram_controller_if;
  logic        MEM_R_En;
  logic        MEM_W_En;
  logic [31:0] Address;
  logic [31:0] ST_Value;
  logic [31:0] Read_Data;
  logic        Ready;

  modport master (output MEM_R_En, MEM_W_En, Address, ST_Value, input Read_Data, Ready);
  modport slave  (input MEM_R_En, MEM_W_En, Address, ST_Value, output Read_Data, Ready);
endinterface

// File: rtl/sram_controller.sv
// Splits each 32-bit LD/ST into two 16-bit async-SRAM half-accesses (low, then high),
// holding the pipeline off through Ready until the word access is finished.
module sram_controller #(
  parameter int HALF_CYCLES = 2,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst_n,
  sram_controller_if.slave   mem,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic [15:0]        SRAM_DQ_OUT,
  output logic               SRAM_DQ_OE,
  input  logic [15:0]        SRAM_DQ_IN,
  output logic               SRAM_WE_N
);
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(HALF_CYCLES - 1);

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              is_wr;
  logic [31:0]       rd_data;
  logic              req, last;
  logic [SRAM_AW-2:0] word;
  logic              unused_addr;

  assign req  = mem.MEM_R_En | mem.MEM_W_En;
  assign last = (cnt == CNT_LAST);
  assign word = mem.Address[SRAM_AW:2];
  assign unused_addr = ^{mem.Address[31:SRAM_AW+1], mem.Address[1:0]};
  assign mem.Read_Data = rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    mem.Ready  = 1'b0;
    SRAM_WE_N  = 1'b1;
    SRAM_DQ_OE = 1'b0;
    case (state)
      IDLE: begin
        mem.Ready = ~req;
        if (req) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end
      end
      LOW: begin
        SRAM_WE_N  = ~is_wr;
        SRAM_DQ_OE = is_wr;
        if (last) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      HIGH: begin
        SRAM_WE_N  = ~is_wr;
        SRAM_DQ_OE = is_wr;
        if (last) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      DONE: begin
        mem.Ready = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes and address are captured once in IDLE; the high half reuses the latched word index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_wr       <= 1'b0;
      SRAM_ADDR   <= '0;
      SRAM_DQ_OUT <= '0;
      rd_data     <= '0;
    end else begin
      if (state == IDLE && req) begin
        is_wr     <= mem.MEM_W_En;
        SRAM_ADDR <= {word, 1'b0};
        if (mem.MEM_W_En) SRAM_DQ_OUT <= mem.ST_Value[15:0];
      end
      if (state == LOW && last) begin
        SRAM_ADDR <= {SRAM_ADDR[SRAM_AW-1:1], 1'b1};
        if (is_wr) SRAM_DQ_OUT <= mem.ST_Value[31:16];
        else       rd_data[15:0] <= SRAM_DQ_IN;
      end
      if (state == HIGH && last && !is_wr) rd_data[31:16] <= SRAM_DQ_IN;
    end
  end
endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: HALF_CYCLES=2 instance on a behavioural SRAM, plus a
// HALF_CYCLES=1 instance for the address-wrap boundary.
module tb_sram_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  sram_controller_if u_if ();
  sram_controller_if u_if2 ();

  logic [17:0] addr, addr2;
  logic [15:0] dq_out, dq_out2, dq_in, dq_in2;
  logic        oe, oe2, we_n, we_n2;

  sram_controller #(.HALF_CYCLES(2), .SRAM_AW(18)) u_dut (
    .clk(clk), .rst_n(rst_n), .mem(u_if),
    .SRAM_ADDR(addr), .SRAM_DQ_OUT(dq_out), .SRAM_DQ_OE(oe),
    .SRAM_DQ_IN(dq_in), .SRAM_WE_N(we_n)
  );

  sram_controller #(.HALF_CYCLES(1), .SRAM_AW(18)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .mem(u_if2),
    .SRAM_ADDR(addr2), .SRAM_DQ_OUT(dq_out2), .SRAM_DQ_OE(oe2),
    .SRAM_DQ_IN(dq_in2), .SRAM_WE_N(we_n2)
  );

  // Behavioural SRAM: latches DQ on each clock where WE_N is low, reads combinationally.
  logic [15:0] sram_mem [0:(1<<18)-1];
  always @(posedge clk) if (!we_n) sram_mem[addr] <= dq_out;
  assign dq_in  = sram_mem[addr];
  assign dq_in2 = ~addr2[15:0];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    u_if.MEM_R_En = 0; u_if.MEM_W_En = 0; u_if.Address = 0; u_if.ST_Value = 0;
    u_if2.MEM_R_En = 0; u_if2.MEM_W_En = 0; u_if2.Address = 0; u_if2.ST_Value = 0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (u_if.Read_Data !== 32'h0) begin n_err++; $display("FAIL rst_read_data got %h exp 0", u_if.Read_Data); end
    n_cmp++; if (we_n !== 1'b1) begin n_err++; $display("FAIL rst_we_n got %b exp 1", we_n); end
    n_cmp++; if (oe !== 1'b0) begin n_err++; $display("FAIL rst_oe got %b exp 0", oe); end
    n_cmp++; if (addr !== 18'h0 || addr2 !== 18'h0) begin n_err++; $display("FAIL rst_addr got %h/%h exp 0", addr, addr2); end
    n_cmp++; if (dq_out !== 16'h0) begin n_err++; $display("FAIL rst_dq_out got %h exp 0", dq_out); end
    @(negedge clk) rst_n = 1'b1;
    tick();
    // start a write, then pull reset while it is in LOW
    u_if.MEM_W_En = 1; u_if.Address = 32'h800; u_if.ST_Value = 32'h5555_AAAA;
    tick();
    n_cmp++; if (we_n !== 1'b0 || oe !== 1'b1) begin n_err++; $display("FAIL rst_mid_active we_n %b oe %b exp 0/1", we_n, oe); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (we_n !== 1'b1 || oe !== 1'b0) begin n_err++; $display("FAIL rst_async_abort we_n %b oe %b exp 1/0", we_n, oe); end
    u_if.MEM_W_En = 0;
    #1;
    n_cmp++; if (u_if.Ready !== 1'b1 || u_if2.Ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b/%b exp 1", u_if.Ready, u_if2.Ready); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (u_if.Ready !== 1'b1 || we_n !== 1'b1) begin n_err++; $display("FAIL rst_idle ready %b we_n %b exp 1/1", u_if.Ready, we_n); end
  endtask

  task automatic test_store();
    logic [17:0] ea;
    logic [15:0] ed;
    u_if.MEM_W_En = 1; u_if.Address = 32'h0000_0408; u_if.ST_Value = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if (u_if.Ready !== 1'b0 || we_n !== 1'b1) begin n_err++; $display("FAIL st_idle ready %b we_n %b exp 0/1", u_if.Ready, we_n); end
    for (int i = 0; i < 4; i++) begin
      tick();
      ea = (i < 2) ? 18'h204 : 18'h205;
      ed = (i < 2) ? 16'hBEEF : 16'hDEAD;
      n_cmp++; if (addr !== ea || dq_out !== ed) begin n_err++; $display("FAIL st_bus cyc%0d addr %h dq %h exp %h %h", i, addr, dq_out, ea, ed); end
      n_cmp++; if (u_if.Ready !== 1'b0 || we_n !== 1'b0 || oe !== 1'b1) begin n_err++; $display("FAIL st_ctl cyc%0d ready %b we_n %b oe %b exp 0/0/1", i, u_if.Ready, we_n, oe); end
    end
    tick();
    n_cmp++; if (u_if.Ready !== 1'b1 || we_n !== 1'b1 || oe !== 1'b0 || addr !== 18'h205) begin
      n_err++; $display("FAIL st_done ready %b we_n %b oe %b addr %h exp 1/1/0/205", u_if.Ready, we_n, oe, addr); end
    u_if.MEM_W_En = 0;
    tick();
    n_cmp++; if (u_if.Ready !== 1'b1 || addr !== 18'h205 || dq_out !== 16'hDEAD) begin
      n_err++; $display("FAIL st_hold ready %b addr %h dq %h exp 1/205/dead", u_if.Ready, addr, dq_out); end
  endtask

  task automatic test_load();
    u_if.MEM_R_En = 1; u_if.Address = 32'h0000_0408;
    #1;
    n_cmp++; if (u_if.Ready !== 1'b0) begin n_err++; $display("FAIL ld_idle ready %b exp 0", u_if.Ready); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (u_if.Ready !== 1'b0 || we_n !== 1'b1 || oe !== 1'b0) begin
        n_err++; $display("FAIL ld_ctl cyc%0d ready %b we_n %b oe %b exp 0/1/0", i, u_if.Ready, we_n, oe); end
    end
    tick();
    n_cmp++; if (u_if.Ready !== 1'b1 || u_if.Read_Data !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL ld_done ready %b data %h exp 1 deadbeef", u_if.Ready, u_if.Read_Data); end
    u_if.MEM_R_En = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic        wr [3];
    logic [31:0] ad [3];
    logic [31:0] sv [3];
    logic [31:0] er [3];
    wr = '{1'b1, 1'b0, 1'b1};
    ad = '{32'h20, 32'h20, 32'h408};
    sv = '{32'h0BAD_CAFE, 32'h0, 32'h1357_9BDF};
    er = '{32'hDEAD_BEEF, 32'h0BAD_CAFE, 32'h0BAD_CAFE};
    for (int k = 0; k < 3; k++) begin
      // next instruction is presented in the DONE cycle; the controller must idle one cycle
      u_if.MEM_W_En = wr[k]; u_if.MEM_R_En = ~wr[k]; u_if.Address = ad[k]; u_if.ST_Value = sv[k];
      if (k == 0) #1; else tick();
      n_cmp++; if (u_if.Ready !== 1'b0 || we_n !== 1'b1) begin n_err++; $display("FAIL b2b_gap acc%0d ready %b we_n %b exp 0/1", k, u_if.Ready, we_n); end
      for (int i = 0; i < 4; i++) begin
        tick();
        n_cmp++; if (u_if.Ready !== 1'b0 || we_n !== ~wr[k]) begin
          n_err++; $display("FAIL b2b_busy acc%0d cyc%0d ready %b we_n %b exp 0/%b", k, i, u_if.Ready, we_n, ~wr[k]); end
      end
      tick();
      n_cmp++; if (u_if.Ready !== 1'b1 || u_if.Read_Data !== er[k]) begin
        n_err++; $display("FAIL b2b_done acc%0d ready %b data %h exp 1 %h", k, u_if.Ready, u_if.Read_Data, er[k]); end
    end
    u_if.MEM_W_En = 0; u_if.MEM_R_En = 0;
    tick();
  endtask

  task automatic test_both_and_quiet();
    u_if.MEM_R_En = 1; u_if.MEM_W_En = 1; u_if.Address = 32'h20; u_if.ST_Value = 32'h1111_2222;
    #1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (we_n !== 1'b0 || oe !== 1'b1 || dq_out !== ((i < 2) ? 16'h2222 : 16'h1111)) begin
        n_err++; $display("FAIL both_wr cyc%0d we_n %b oe %b dq %h", i, we_n, oe, dq_out); end
    end
    tick();
    n_cmp++; if (u_if.Ready !== 1'b1 || u_if.Read_Data !== 32'h0BAD_CAFE) begin
      n_err++; $display("FAIL both_done ready %b data %h exp 1 0badcafe", u_if.Ready, u_if.Read_Data); end
    u_if.MEM_R_En = 0; u_if.MEM_W_En = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (u_if.Ready !== 1'b1 || we_n !== 1'b1 || oe !== 1'b0) begin
        n_err++; $display("FAIL quiet cyc%0d ready %b we_n %b oe %b exp 1/1/0", i, u_if.Ready, we_n, oe); end
    end
    n_cmp++; if (sram_mem[18'h10] !== 16'h2222 || sram_mem[18'h11] !== 16'h1111) begin
      n_err++; $display("FAIL both_mem got %h %h exp 1111 2222", sram_mem[18'h11], sram_mem[18'h10]); end
  endtask

  task automatic test_wrap_hc1();
    u_if2.MEM_R_En = 1; u_if2.Address = 32'hFFFF_FFFC;
    #1;
    n_cmp++; if (u_if2.Ready !== 1'b0) begin n_err++; $display("FAIL wrap_idle ready %b exp 0", u_if2.Ready); end
    tick();
    n_cmp++; if (addr2 !== 18'h3FFFE || u_if2.Ready !== 1'b0) begin n_err++; $display("FAIL wrap_low addr %h ready %b exp 3fffe/0", addr2, u_if2.Ready); end
    tick();
    n_cmp++; if (addr2 !== 18'h3FFFF || u_if2.Ready !== 1'b0) begin n_err++; $display("FAIL wrap_high addr %h ready %b exp 3ffff/0", addr2, u_if2.Ready); end
    tick();
    n_cmp++; if (u_if2.Ready !== 1'b1 || u_if2.Read_Data !== 32'h0000_0001) begin
      n_err++; $display("FAIL wrap_done ready %b data %h exp 1 00000001", u_if2.Ready, u_if2.Read_Data); end
    u_if2.MEM_R_En = 0;
    tick();
    n_cmp++; if (u_if2.Ready !== 1'b1 || we_n2 !== 1'b1 || oe2 !== 1'b0 || dq_out2 !== 16'h0) begin
      n_err++; $display("FAIL wrap_idle_after ready %b we_n %b oe %b dq %h", u_if2.Ready, we_n2, oe2, dq_out2); end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_back_to_back();
    test_both_and_quiet();
    test_wrap_hc1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
